// File: rtl/ins_encoder_pkg.sv
// Shared field-set definitions for the RV32 encoder/decoder pair.
// Defines INS_BUS / Imm_20 widths; ENC_IMM_CHECK_EN is consumed by ins_encoder.
`ifndef INS_ENCODER_DEFS
`define INS_ENCODER_DEFS
`define INS_BUS 32
`define Imm_20 20
`endif

package ins_encoder_pkg;

    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    typedef struct packed {
        logic [6:0]          opcode;
        logic [4:0]          rd;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [2:0]          fct3;
        logic [6:0]          fct7;
        logic [`Imm_20-1:0]  imm;
    } ins_fields_t;

endpackage

// File: rtl/ins_enc_fifo.sv
// Two-entry FIFO of {ins, addr}; the head slot drives the outputs directly.
import ins_encoder_pkg::*;

module ins_enc_fifo #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                push,
    input  logic [`INS_BUS-1:0] push_ins,
    input  logic [ADDR_W-1:0]   push_addr,
    input  logic                pop,
    output logic                not_full,
    output logic                head_valid,
    output logic [`INS_BUS-1:0] head_ins,
    output logic [ADDR_W-1:0]   head_addr
);

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    logic [`INS_BUS-1:0] head_ins_q, head_ins_d, tail_ins_q, tail_ins_d;
    logic [ADDR_W-1:0]   head_addr_q, head_addr_d, tail_addr_q, tail_addr_d;
    logic [1:0]          count_q, count_d;
    logic                push_ok, pop_ok;

    assign not_full   = (count_q != 2'd2);
    assign head_valid = (count_q != 2'd0);
    assign head_ins   = head_ins_q;
    assign head_addr  = head_addr_q;
    assign push_ok    = push && not_full;
    assign pop_ok     = pop && head_valid;

    always_comb begin
        head_ins_d  = head_ins_q;
        head_addr_d = head_addr_q;
        tail_ins_d  = tail_ins_q;
        tail_addr_d = tail_addr_q;
        count_d     = count_q;
        if (clear) begin
            count_d = 2'd0;
        end else begin
            case ({push_ok, pop_ok})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        head_ins_d  = push_ins;
                        head_addr_d = push_addr;
                    end else begin
                        tail_ins_d  = push_ins;
                        tail_addr_d = push_addr;
                    end
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    // Only shift when a second entry exists so an emptied head holds its value.
                    if (count_q == 2'd2) begin
                        head_ins_d  = tail_ins_q;
                        head_addr_d = tail_addr_q;
                    end
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    head_ins_d  = push_ins;
                    head_addr_d = push_addr;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_ins_q  <= '0;
            head_addr_q <= BASE;
            tail_ins_q  <= '0;
            tail_addr_q <= BASE;
            count_q     <= 2'd0;
        end else begin
            head_ins_q  <= head_ins_d;
            head_addr_q <= head_addr_d;
            tail_ins_q  <= tail_ins_d;
            tail_addr_q <= tail_addr_d;
            count_q     <= count_d;
        end
    end

endmodule

// File: rtl/ins_encoder.sv
// RV32 field-set to instruction-word encoder with address tagging and error tracking.
// Optional macro ENC_IMM_CHECK_EN rejects field sets with nonzero unused bits.
import ins_encoder_pkg::*;

module ins_encoder #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [6:0]          in_opcode,
    input  logic [4:0]          in_rd,
    input  logic [4:0]          in_rs1,
    input  logic [4:0]          in_rs2,
    input  logic [2:0]          in_fct3,
    input  logic [6:0]          in_fct7,
    input  logic [`Imm_20-1:0]  in_imm,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [`INS_BUS-1:0] out_ins,
    output logic [ADDR_W-1:0]   out_addr,
    output logic                err,
    output logic [7:0]          err_cnt
);

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    ins_fields_t         f;
    logic [`INS_BUS-1:0] ins_w;
    logic                legal, accept, push, bad, pop;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                err_q, err_d;
    logic [7:0]          err_cnt_q, err_cnt_d;

    assign f = '{opcode: in_opcode, rd: in_rd, rs1: in_rs1, rs2: in_rs2,
                 fct3: in_fct3, fct7: in_fct7, imm: in_imm};

    always_comb begin
        ins_w = '0;
        legal = 1'b1;
        case (f.opcode)
            OP_RTYPE: begin
                ins_w = {f.fct7, f.rs2, f.rs1, f.fct3, f.rd, f.opcode};
`ifdef ENC_IMM_CHECK_EN
                legal = (f.imm == '0);
`endif
            end
            OP_ITYPE, OP_LOAD: begin
                ins_w = {f.imm[19:8], f.rs1, f.fct3, f.rd, f.opcode};
`ifdef ENC_IMM_CHECK_EN
                legal = (f.imm[7:0] == 8'd0) && (f.rs2 == 5'd0) && (f.fct7 == 7'd0);
`endif
            end
            OP_LUI, OP_AUIPC: begin
                ins_w = {f.imm, f.rd, f.opcode};
`ifdef ENC_IMM_CHECK_EN
                legal = ({f.rs1, f.rs2, f.fct3, f.fct7} == '0);
`endif
            end
            OP_JAL: begin
                // Decoder packs the J offset as offset[20:1] in natural bit order.
                ins_w = {f.imm[19], f.imm[9:0], f.imm[10], f.imm[18:11], f.rd, f.opcode};
`ifdef ENC_IMM_CHECK_EN
                legal = ({f.rs1, f.rs2, f.fct3, f.fct7} == '0);
`endif
            end
            default: legal = 1'b0;
        endcase
    end

    assign accept = in_valid && in_ready;
    assign push   = accept && legal && !clear;
    assign bad    = accept && !legal && !clear;
    assign pop    = out_valid && out_ready && !clear;

    always_comb begin
        addr_d    = addr_q;
        err_d     = err_q | bad;
        err_cnt_d = err_cnt_q;
        if (clear)
            addr_d = BASE;
        else if (push)
            addr_d = addr_q + 1'b1;
        if (bad && err_cnt_q != 8'hFF)
            err_cnt_d = err_cnt_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q    <= BASE;
            err_q     <= 1'b0;
            err_cnt_q <= 8'd0;
        end else begin
            addr_q    <= addr_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err     = err_q;
    assign err_cnt = err_cnt_q;

    ins_enc_fifo #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .push       (push),
        .push_ins   (ins_w),
        .push_addr  (addr_q),
        .pop        (pop),
        .not_full   (in_ready),
        .head_valid (out_valid),
        .head_ins   (out_ins),
        .head_addr  (out_addr)
    );

endmodule

// File: tb/tb_ins_encoder.sv
// Directed bench for ins_encoder built with a 2-bit address counter to exercise wrap.
import ins_encoder_pkg::*;

module tb_ins_encoder;

    logic        clk = 1'b0;
    logic        rst_n, clear, in_valid, in_ready, out_valid, out_ready, err;
    logic [6:0]  in_opcode, in_fct7;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [2:0]  in_fct3;
    logic [19:0] in_imm;
    logic [31:0] out_ins;
    logic [1:0]  out_addr;
    logic [7:0]  err_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ins_encoder #(.ADDR_W(2), .BASE_ADDR(0)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_fct3(in_fct3), .in_fct7(in_fct7), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_ins(out_ins),
        .out_addr(out_addr), .err(err), .err_cnt(err_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [19:0] imm);
        in_valid  = 1'b1;
        in_opcode = op;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_fct3   = f3;
        in_fct7   = f7;
        in_imm    = imm;
    endtask

    task automatic lui1(input logic [19:0] imm);
        drive(7'b0110111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, imm);
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        in_fct3 = '0; in_fct7 = '0; in_imm = '0;
        #3;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_ins", out_ins, 32'h0);
        chk("rst_out_addr", 32'(out_addr), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // addi x1,x0,5
        drive(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 20'h00500);
        tick(); in_valid = 1'b0;
        chk("addi_valid", 32'(out_valid), 32'd1);
        chk("addi_ins", out_ins, 32'h00500093);
        chk("addi_addr", 32'(out_addr), 32'd0);
        tick();
        chk("addi_popped", 32'(out_valid), 32'd0);

        // add x3,x1,x2 then lui x5,0x12345 after a clear
        clear = 1'b1; tick(); clear = 1'b0;
        drive(7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 20'h0);
        tick();
        chk("add_ins", out_ins, 32'h002081B3);
        chk("add_addr", 32'(out_addr), 32'd0);
        drive(7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 20'h12345);
        tick(); in_valid = 1'b0;
        chk("lui_valid", 32'(out_valid), 32'd1);
        chk("lui_ins", out_ins, 32'h123452B7);
        chk("lui_addr", 32'(out_addr), 32'd1);
        tick();

        // jal x1,+8
        drive(7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 20'h00004);
        tick(); in_valid = 1'b0;
        chk("jal_ins", out_ins, 32'h008000EF);
        chk("jal_addr", 32'(out_addr), 32'd2);
        tick();

        // illegal branch opcode
        drive(7'b1100011, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 20'h00010);
        tick(); in_valid = 1'b0;
        chk("br_no_out", 32'(out_valid), 32'd0);
        chk("br_err", 32'(err), 32'd1);
        chk("br_err_cnt", 32'(err_cnt), 32'd1);
        chk("br_in_ready", 32'(in_ready), 32'd1);
        drive(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 20'h00500);
        tick(); in_valid = 1'b0;
        chk("after_br_addr", 32'(out_addr), 32'd3);
        chk("after_br_ins", out_ins, 32'h00500093);
        tick();

        // backpressure: counter wrapped to 0
        out_ready = 1'b0;
        lui1(20'h00001); tick();
        chk("bp1_in_ready", 32'(in_ready), 32'd1);
        chk("bp1_ins", out_ins, 32'h000010B7);
        chk("bp1_addr", 32'(out_addr), 32'd0);
        lui1(20'h00002); tick();
        chk("bp2_in_ready", 32'(in_ready), 32'd0);
        chk("bp2_ins_stable", out_ins, 32'h000010B7);
        lui1(20'h00003); tick();
        chk("bp3_in_ready", 32'(in_ready), 32'd0);
        chk("bp3_ins_stable", out_ins, 32'h000010B7);
        chk("bp3_addr_stable", 32'(out_addr), 32'd0);
        out_ready = 1'b1; tick();
        chk("drain1_in_ready", 32'(in_ready), 32'd1);
        chk("drain1_ins", out_ins, 32'h000020B7);
        chk("drain1_addr", 32'(out_addr), 32'd1);
        tick(); in_valid = 1'b0;
        chk("drain2_valid", 32'(out_valid), 32'd1);
        chk("drain2_ins", out_ins, 32'h000030B7);
        chk("drain2_addr", 32'(out_addr), 32'd2);
        tick();
        chk("drain_empty", 32'(out_valid), 32'd0);

        // address wrap with ADDR_W=2
        clear = 1'b1; tick(); clear = 1'b0;
        chk("clear_keeps_err", 32'(err), 32'd1);
        for (int k = 0; k < 5; k++) begin
            lui1(20'(k + 1)); tick();
            chk($sformatf("wrap%0d_addr", k), 32'(out_addr), 32'(k % 4));
            chk($sformatf("wrap%0d_ins", k), out_ins, ((k + 1) << 12) | 32'hB7);
        end
        in_valid = 1'b0; tick();

        // clear mid-stream beats a simultaneous accept
        out_ready = 1'b0;
        lui1(20'h00007); tick(); in_valid = 1'b0;
        chk("mid_valid", 32'(out_valid), 32'd1);
        chk("mid_addr", 32'(out_addr), 32'd1);
        clear = 1'b1; lui1(20'h00008); tick(); clear = 1'b0; in_valid = 1'b0;
        chk("clr_empty", 32'(out_valid), 32'd0);
        chk("clr_in_ready", 32'(in_ready), 32'd1);
        chk("clr_err_cnt", 32'(err_cnt), 32'd1);
        out_ready = 1'b1;
        lui1(20'h00009); tick(); in_valid = 1'b0;
        chk("clr_next_addr", 32'(out_addr), 32'd0);
        chk("clr_next_ins", out_ins, 32'h000090B7);
        tick();

        // err_cnt saturation
        drive(7'b1111111, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 20'h0);
        repeat (260) tick();
        in_valid = 1'b0;
        chk("sat_err_cnt", 32'(err_cnt), 32'd255);
        chk("sat_no_out", 32'(out_valid), 32'd0);
        tick();

        // asynchronous reset mid-stream
        out_ready = 1'b0;
        lui1(20'h0000A); tick(); in_valid = 1'b0;
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_out_ins", out_ins, 32'h0);
        chk("arst_out_addr", 32'(out_addr), 32'd0);
        chk("arst_err", 32'(err), 32'd0);
        chk("arst_err_cnt", 32'(err_cnt), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ins_encoder.md
# ins_encoder

Sequential RV32 instruction encoder. It is the inverse of the CPU's field decoder: it accepts decoded instruction fields (opcode, rd, rs1, rs2, fct3, fct7, packed 20-bit imm) over a valid/ready handshake and reassembles the 32-bit instruction word. Each word is pushed into a 2-entry output buffer tagged with a sequential instruction-memory word address. The block sits between the test/program loader and instruction memory, so the loader can write programs as fields and round-trip them through the decoder.

## Interface
- ADDR_W, 8: width of the output word-address counter.
- BASE_ADDR, 0: address value assigned to the first word after reset or clear.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous; flushes the buffer and reloads the address counter to BASE_ADDR. Does not clear err.
- in_valid  input  1  field set present.
- in_ready  output  1  block can accept a field set (buffer count < 2).
- in_opcode  input  7  instruction[6:0].
- in_rd, in_rs1, in_rs2  input  5 each  register fields.
- in_fct3  input  3  funct3.
- in_fct7  input  7  funct7.
- in_imm  input  20  packed immediate, in the decoder's packing (`Imm_20).
- out_valid  output  1  buffer head valid.
- out_ready  input  1  consumer accepts the head.
- out_ins  output  32  encoded word at the head.
- out_addr  output  ADDR_W  word address of the head.
- err  output  1  sticky flag for an illegal field set.
- err_cnt  output  8  saturating count of illegal field sets.

## Operation
- Accept on in_valid && in_ready; pop on out_valid && out_ready.
- Encoding by opcode. Unused fields are ignored.
  - 0110011 (R): {fct7, rs2, rs1, fct3, rd, op}.
  - 0010011 and 0000011 (I): {imm[19:8], rs1, fct3, rd, op}.
  - 0110111 and 0010111 (U): {imm[19:0], rd, op}.
  - 1101111 (J): {imm[19], imm[9:0], imm[10], imm[18:11], rd, op}.
- Any other opcode is illegal. The field set is accepted (handshake completes) but not pushed. err is set, err_cnt increments and saturates at 255, and the address counter does not advance.
- Each legal word is pushed with the current address counter value, then the counter increments by 1. The counter wraps modulo 2^ADDR_W.
- The buffer is a 2-entry FIFO with head on out_*.
- Pop and push in the same cycle: allowed whenever in_ready=1, and count is unchanged.
- in_ready depends on registered count only, never on out_ready.
- clear has priority over a simultaneous accept and pop; that cycle's input is discarded.

## Timing
- Reset values:
  - in_ready=1, out_valid=0, out_ins=0, out_addr=BASE_ADDR.
  - err=0, err_cnt=0, count=0, address counter=BASE_ADDR.
- Latency: a field set accepted in cycle N appears on out_* in cycle N+1 if the buffer was empty.
- out_ins and out_addr are stable while out_valid && !out_ready.
- Full (count=2): in_ready=0. A pop in that cycle raises in_ready in the next cycle.
- Empty: out_valid=0. out_ins and out_addr hold their last values and are don't-care.
- rst_n asserted mid-stream: buffer contents are lost immediately (asynchronous) and all outputs return to reset values.

## Configuration
- ENC_IMM_CHECK_EN defined: an I-type field set with in_imm[7:0]≠0, or any field set with nonzero bits in fields unused by its format, is treated as illegal (dropped, err set, err_cnt incremented).
- ENC_IMM_CHECK_EN undefined: unused bits are silently ignored and no check logic is built.

## Structure
- Shared package/defines:
  - opcode constants OP_RTYPE, OP_ITYPE, OP_LOAD, OP_LUI, OP_AUIPC, OP_JAL.
  - the `INS_BUS / `Imm_20 widths.
  - a field-set struct/typedef shared with the decoder.
- Sub-module ins_enc_fifo: 2-entry FIFO carrying {ins, addr}.
- The top level holds the combinational pack logic, the address counter and the error logic.

## Test plan
- addi x1,x0,5: op=0010011, rd=1, rs1=0, fct3=0, imm=20'h00500 -> out_ins=32'h00500093, out_addr=0, one cycle after accept.
- add x3,x1,x2 (op=0110011, rd=3, rs1=1, rs2=2, fct7=0), then lui x5,0x12345 (op=0110111, rd=5, imm=20'h12345) -> 32'h002081B3 at addr 0, then 32'h123452B7 at addr 1.
- jal x1,+8: op=1101111, rd=1, imm=20'h00004 -> 32'h008000EF.
- op=1100011 (branch) -> no output, err=1, err_cnt=1, next legal word still gets the unincremented address.
- out_ready=0 with three back-to-back inputs -> in_ready drops after two accepts. out_ins is stable. Raising out_ready drains in order and in_ready returns one cycle after the first pop.
- ADDR_W=2: push 5 words -> addresses 0,1,2,3,0. Mid-stream clear -> buffer empty next cycle, next address=BASE_ADDR. Asserting rst_n low -> out_valid=0 immediately.
